// File: rtl/call_return_ctrl.sv
// Call/return sequencer: turns decoded CALL/RET requests into return-address-stack
// push/pop strobes and issues a one-cycle PC redirect to fetch.
module call_return_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_call,
    input  logic             req_ret,
    input  logic [WIDTH-1:0] req_pc,
    input  logic [WIDTH-1:0] req_target,
    output logic             stk_en,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_d,
    input  logic [WIDTH-1:0] stk_q,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [DEPTH:0]   level,
    output logic             fault,
    output logic [1:0]       fault_code
);

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        POP,
        RDATA,
        FAULT
    } state_t;

    localparam logic [DEPTH:0] FULL = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0] ONE  = (DEPTH+1)'(1);

    state_t state;

    // Outputs are registered on the transition into each state, so the strobes of
    // PUSH/POP are visible for exactly the one cycle the FSM spends there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            stk_en         <= 1'b0;
            stk_push       <= 1'b0;
            stk_pop        <= 1'b0;
            stk_d          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            level          <= '0;
            fault          <= 1'b0;
            fault_code     <= 2'd0;
        end else begin
            stk_en         <= 1'b0;
            stk_push       <= 1'b0;
            stk_pop        <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (req_call == req_ret) begin
                            state      <= FAULT;
                            fault      <= 1'b1;
                            fault_code <= 2'd3;
                        end else if (req_call) begin
                            if (level == FULL) begin
                                state      <= FAULT;
                                fault      <= 1'b1;
                                fault_code <= 2'd1;
                            end else begin
                                state          <= PUSH;
                                stk_en         <= 1'b1;
                                stk_push       <= 1'b1;
                                stk_d          <= req_pc + WIDTH'(1);
                                redirect_valid <= 1'b1;
                                redirect_pc    <= req_target;
                                level          <= level + ONE;
                            end
                        end else begin
                            if (level == '0) begin
                                state      <= FAULT;
                                fault      <= 1'b1;
                                fault_code <= 2'd2;
                            end else begin
                                state   <= POP;
                                stk_en  <= 1'b1;
                                stk_pop <= 1'b1;
                                level   <= level - ONE;
                            end
                        end
                    end
                end
                PUSH: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                POP: begin
                    state <= RDATA;
                end
                // Stack output now holds the entry popped on the previous edge.
                RDATA: begin
                    state          <= IDLE;
                    req_ready      <= 1'b1;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= stk_q;
                end
                FAULT: begin
                    req_ready <= 1'b0;
                    fault     <= 1'b1;
                end
                default: begin
                    state      <= FAULT;
                    req_ready  <= 1'b0;
                    fault      <= 1'b1;
                    fault_code <= 2'd3;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Self-checking bench for call_return_ctrl with a behavioural return-address stack
// and scoreboard queues for expected push data and redirect targets.
module tb_call_return_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
    localparam int CAP   = 1 << DEPTH;

    logic             clk;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             req_call;
    logic             req_ret;
    logic [WIDTH-1:0] req_pc;
    logic [WIDTH-1:0] req_target;
    logic             stk_en;
    logic             stk_push;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_d;
    logic [WIDTH-1:0] stk_q;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic [DEPTH:0]   level;
    logic             fault;
    logic [1:0]       fault_code;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] push_q[$];
    logic [WIDTH-1:0] redir_q[$];
    int               exp_pops = 0;
    int               model_level = 0;

    call_return_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_call(req_call), .req_ret(req_ret),
        .req_pc(req_pc), .req_target(req_target),
        .stk_en(stk_en), .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_d(stk_d), .stk_q(stk_q),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .level(level), .fault(fault), .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack: one-cycle read latency, q holds the popped entry.
    logic [WIDTH-1:0] mem [0:CAP-1];
    int sp;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp    <= 0;
            stk_q <= '0;
        end else if (stk_en) begin
            if (stk_push && sp < CAP) begin
                mem[sp] <= stk_d;
                sp      <= sp + 1;
            end else if (stk_pop && sp > 0) begin
                stk_q <= mem[sp-1];
                sp    <= sp - 1;
            end
        end
    end

    // Scoreboard: every strobe seen must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (stk_en && stk_push) begin
                checks++;
                if (push_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_push stk_d=%h", stk_d);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = push_q.pop_front();
                    if (stk_d !== e) begin
                        errors++;
                        $display("FAIL push_data got=%h exp=%h", stk_d, e);
                    end
                end
            end
            if (stk_en && stk_pop) begin
                checks++;
                if (exp_pops == 0) begin
                    errors++;
                    $display("FAIL unexpected_pop level=%0d", level);
                end else begin
                    exp_pops--;
                end
            end
            if (stk_push && stk_pop) begin
                errors++;
                $display("FAIL push_and_pop got=11 exp=not both");
            end
            if (redirect_valid) begin
                checks++;
                if (redir_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_redirect pc=%h", redirect_pc);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = redir_q.pop_front();
                    if (redirect_pc !== e) begin
                        errors++;
                        $display("FAIL redirect_pc got=%h exp=%h", redirect_pc, e);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_call  = 1'b0;
        req_ret   = 1'b0;
        push_q.delete();
        redir_q.delete();
        exp_pops    = 0;
        model_level = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got=0 exp=1");
        end
    endtask

    // Drives one request through the handshake; returns #1 after the accept edge.
    task automatic send(input logic c, input logic r,
                        input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] tgt);
        wait_ready();
        req_valid  = 1'b1;
        req_call   = c;
        req_ret    = r;
        req_pc     = pc;
        req_target = tgt;
        if (c && !r && model_level < CAP) begin
            push_q.push_back(pc + 32'd1);
            redir_q.push_back(tgt);
            model_level++;
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_call   = 1'b0;
        req_ret    = 1'b0;
        req_pc     = $urandom;
        req_target = $urandom;
    endtask

    task automatic send_ret(input logic [WIDTH-1:0] exp_pc);
        if (model_level > 0) begin
            exp_pops++;
            redir_q.push_back(exp_pc);
            model_level--;
        end
        send(1'b0, 1'b1, '0, '0);
    endtask

    task automatic drain_check(input string name);
        wait_ready();
        repeat (2) @(posedge clk); #1;
        checks++;
        if (push_q.size() != 0 || redir_q.size() != 0 || exp_pops != 0) begin
            errors++;
            $display("FAIL %s_pending got=%0d/%0d/%0d exp=0/0/0", name,
                     push_q.size(), redir_q.size(), exp_pops);
        end
        checks++;
        if (level !== (DEPTH+1)'(model_level)) begin
            errors++;
            $display("FAIL %s_level got=%0d exp=%0d", name, level, model_level);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({req_ready, stk_en, stk_push, stk_pop, redirect_valid, fault} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=100000",
                     {req_ready, stk_en, stk_push, stk_pop, redirect_valid, fault});
        end
        checks++;
        if (level !== '0 || fault_code !== 2'd0 || stk_d !== '0 || redirect_pc !== '0) begin
            errors++;
            $display("FAIL reset_values got=%0d/%0d/%h/%h exp=0/0/0/0",
                     level, fault_code, stk_d, redirect_pc);
        end
    endtask

    task automatic test_call();
        send(1'b1, 1'b0, 32'h100, 32'h400);
        checks++;
        if (stk_push !== 1'b1 || stk_d !== 32'h101 || redirect_pc !== 32'h400 || level !== 4'd1) begin
            errors++;
            $display("FAIL call_t1 got=push%b d=%h rpc=%h lvl=%0d exp=push1 d=101 rpc=400 lvl=1",
                     stk_push, stk_d, redirect_pc, level);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || stk_en !== 1'b0) begin
            errors++;
            $display("FAIL call_t2 got=rdy%b en%b exp=rdy1 en0", req_ready, stk_en);
        end
    endtask

    task automatic test_call_ret();
        send_ret(32'h101);
        checks++;
        if (stk_pop !== 1'b1 || level !== 4'd0 || redirect_valid !== 1'b0) begin
            errors++;
            $display("FAIL ret_t1 got=pop%b lvl=%0d rv=%b exp=pop1 lvl=0 rv=0",
                     stk_pop, level, redirect_valid);
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h101) begin
            errors++;
            $display("FAIL ret_t2 got=rv%b pc=%h exp=rv1 pc=101", redirect_valid, redirect_pc);
        end
        drain_check("call_ret");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] pcs[$];
        for (int i = 0; i < 5; i++) begin
            logic [WIDTH-1:0] p;
            p = $urandom;
            pcs.push_back(p + 32'd1);
            send(1'b1, 1'b0, p, $urandom);
        end
        for (int i = 0; i < 2; i++) send_ret(pcs.pop_back());
        send(1'b1, 1'b0, 32'h2000, 32'h3000);
        pcs.push_back(32'h2001);
        while (pcs.size() > 0) send_ret(pcs.pop_back());
        drain_check("back_to_back");
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < CAP; i++) send(1'b1, 1'b0, 32'h1000 + 32'(i), 32'h8000 + 32'(i));
        drain_check("fill");
        send(1'b1, 1'b0, 32'h5000, 32'h6000);
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd1 || level !== 4'd8 || req_ready !== 1'b0 || stk_push !== 1'b0) begin
            errors++;
            $display("FAIL overflow got=f%b c%0d lvl=%0d rdy%b push%b exp=f1 c1 lvl8 rdy0 push0",
                     fault, fault_code, level, req_ready, stk_push);
        end
        // Further requests must be ignored while faulted.
        req_valid = 1'b1; req_ret = 1'b1;
        repeat (3) @(posedge clk); #1;
        req_valid = 1'b0; req_ret = 1'b0;
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd1 || level !== 4'd8 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL overflow_sticky got=f%b c%0d lvl=%0d rdy%b exp=f1 c1 lvl8 rdy0",
                     fault, fault_code, level, req_ready);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        send_ret('0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd2 || level !== 4'd0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL underflow got=f%b c%0d lvl=%0d rdy%b exp=f1 c2 lvl0 rdy0",
                     fault, fault_code, level, req_ready);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        send(1'b1, 1'b0, 32'h10, 32'h20);
        wait_ready();
        send(1'b1, 1'b1, 32'h30, 32'h40);
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd3 || level !== 4'd1) begin
            errors++;
            $display("FAIL illegal_both got=f%b c%0d lvl=%0d exp=f1 c3 lvl1", fault, fault_code, level);
        end
        apply_reset();
        send(1'b0, 1'b0, 32'h30, 32'h40);
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'd3) begin
            errors++;
            $display("FAIL illegal_none got=f%b c%0d exp=f1 c3", fault, fault_code);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        send(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1234);
        checks++;
        if (stk_push !== 1'b1 || stk_d !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap got=push%b d=%h exp=push1 d=00000000", stk_push, stk_d);
        end
        send_ret(32'h0);
        drain_check("wrap");
    endtask

    task automatic test_reset_in_pop();
        send(1'b1, 1'b0, 32'h700, 32'h900);
        send_ret(32'h701);
        checks++;
        if (stk_pop !== 1'b1) begin
            errors++;
            $display("FAIL pop_before_reset got=%b exp=1", stk_pop);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({stk_en, stk_push, stk_pop, redirect_valid} !== 4'b0000 || level !== '0) begin
            errors++;
            $display("FAIL reset_in_pop got=%b lvl=%0d exp=0000 lvl=0",
                     {stk_en, stk_push, stk_pop, redirect_valid}, level);
        end
        push_q.delete();
        redir_q.delete();
        exp_pops    = 0;
        model_level = 0;
        @(posedge clk); #1 reset = 1'b1;
        repeat (4) @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || fault !== 1'b0 || level !== '0) begin
            errors++;
            $display("FAIL after_reset got=rdy%b f%b lvl=%0d exp=rdy1 f0 lvl0", req_ready, fault, level);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_call   = 1'b0;
        req_ret    = 1'b0;
        req_pc     = '0;
        req_target = '0;
        test_reset();
        test_call();
        test_call_ret();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_illegal();
        test_wrap();
        test_reset_in_pop();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
